demux48_serializer_24: RTL and testbench
========================================

Name: demux48_serializer_24

Overview:
- Inverse of the 48-bit 2-to-1 select path.
- Accepts one 48-bit word with a destination select S, then delivers it to one of two 24-bit consumer ports as two sequential beats.
- Sits between 48-bit producers (multiplier product, double-width ALU result) and the 24-bit datapath/register-file write ports.
- Both sides use valid/ready handshakes, so either end can stall.

Parameters:
- WIDTH, 24, beat width; input word is 2*WIDTH.
- HI_FIRST, 0, 0 = low half sent first, 1 = high half sent first.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- Hyrja  input  2*WIDTH  input word.
- S  input  1  destination select: 0 = port 0, 1 = port 1.
- HyrjaValid  input  1  producer presents Hyrja/S.
- HyrjaReady  output  1  block can accept a word this cycle.
- Dalja0  output  WIDTH  beat data, port 0.
- Valid0  output  1  beat valid, port 0.
- Ready0  input  1  consumer 0 accepts beat.
- Dalja1  output  WIDTH  beat data, port 1.
- Valid1  output  1  beat valid, port 1.
- Ready1  input  1  consumer 1 accepts beat.
- Last  output  1  current beat is the second beat of the word (common to both ports).
- Busy  output  1  word held, beats outstanding.

Behaviour:
- Handshake rule: a transfer occurs on a rising edge where valid and ready are both 1. Valid must not depend combinationally on ready.
- Internal state: 48-bit holding register, latched select bit, FSM {IDLE, BEAT1, BEAT2}.
- Reset (Reset=0 at an edge):
  - FSM goes to IDLE.
  - Holding register and select cleared to 0.
  - Valid0 = Valid1 = 0; Last = 0; Busy = 0; HyrjaReady = 1 the cycle after reset.
  - Dalja0 = Dalja1 = 0.
  - Reset overrides everything, including mid-word: any beats outstanding are discarded, not delivered.
- IDLE:
  - HyrjaReady = 1.
  - On HyrjaValid: latch Hyrja and S, go to BEAT1.
- BEAT1:
  - Valid on the latched port only; the other port's Valid stays 0 and its Dalja stays 0.
  - Data is Hyrja[WIDTH-1:0] if HI_FIRST=0, else Hyrja[2*WIDTH-1:WIDTH].
  - Last = 0.
  - On selected Ready, go to BEAT2. Otherwise hold; data and valid stay stable.
- BEAT2:
  - Valid on the same port, carrying the other half; Last = 1.
  - On selected Ready, go to IDLE.
- Ready-through in BEAT2: HyrjaReady = selected Ready while in BEAT2. If HyrjaValid is also 1 that cycle, latch the new word and go directly to BEAT1. Sustained throughput is 1 word per 2 cycles.
- HyrjaReady = 0 in BEAT1.
- HyrjaReady is combinational from state and Ready only, never from HyrjaValid.
- Latency: a word accepted at edge N has its first beat valid in cycle N+1. With both beats accepted on arrival, the second beat is valid in cycle N+2.
- Busy = 1 in BEAT1 and BEAT2.
- Changes to Hyrja/S while not accepted have no effect. S is used only at acceptance.
- The non-selected port's Ready is ignored in all states.
- No data width arithmetic; halves are taken verbatim, with no sign extension.

Test Plan:
- Reset then idle: hold Reset=0 for 2 cycles, release → HyrjaReady=1; Valid0=Valid1=0; Dalja0=Dalja1=0; Busy=0.
- Basic port 0, HI_FIRST=0: Hyrja=48'hABCDEF_123456, S=0, Ready0=1 → cycle+1: Dalja0=24'h123456, Valid0=1, Last=0; cycle+2: Dalja0=24'hABCDEF, Last=1; Valid1 stays 0 throughout.
- Back-pressure on port 1: S=1, Hyrja=48'h000001_FFFFFF, Ready1 held 0 for 3 cycles then 1 → Dalja1=24'hFFFFFF stable for 4 cycles; then 24'h000001 with Last=1; HyrjaReady=0 during the stall.
- Back-to-back: two words (S=0, then S=1) with HyrjaValid held and both Readys=1 → 4 beats in 4 consecutive cycles, alternating Last 0/1; second word on port 1; no idle gap.
- HI_FIRST=1: Hyrja=48'h111111_222222 → first beat 24'h111111, second 24'h222222 with Last=1.
- Reset mid-word: assert Reset=0 while in BEAT2 with Ready0=0 → next cycle Valid0=0, Busy=0, HyrjaReady=1; the pending high half is never delivered.

Source files
------------

// File: rtl/demux48_serializer_24.sv
// Splits one 2*WIDTH word into two WIDTH beats and delivers them, in order,
// to the consumer port picked by S at acceptance. Valid/ready on both sides.
module demux48_serializer_24 #(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned HI_FIRST = 0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [2*WIDTH-1:0] Hyrja,
    input  logic               S,
    input  logic               HyrjaValid,
    output logic               HyrjaReady,
    output logic [WIDTH-1:0]   Dalja0,
    output logic               Valid0,
    input  logic               Ready0,
    output logic [WIDTH-1:0]   Dalja1,
    output logic               Valid1,
    input  logic               Ready1,
    output logic               Last,
    output logic               Busy
);

    localparam int unsigned WordW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WordW-1:0]   word_q, word_d;
    logic               sel_q, sel_d;
    logic [WIDTH-1:0]   dalja0_q, dalja0_d;
    logic [WIDTH-1:0]   dalja1_q, dalja1_d;
    logic               valid0_q, valid0_d;
    logic               valid1_q, valid1_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;

    logic               sel_ready;
    logic               accept;
    logic [WIDTH-1:0]   half_lo, half_hi, beat_first, beat_second, beat_d;

    // Input side ready: free in IDLE, or when the final beat leaves this cycle.
    assign sel_ready  = sel_q ? Ready1 : Ready0;
    assign HyrjaReady = (state_q == IDLE) || ((state_q == BEAT2) && sel_ready);
    assign accept     = HyrjaValid && HyrjaReady;

    // Next-state, holding register and registered beat outputs.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sel_d   = sel_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BEAT1;
                    word_d  = Hyrja;
                    sel_d   = S;
                end
            end
            BEAT1: begin
                if (sel_ready) begin
                    state_d = BEAT2;
                end
            end
            BEAT2: begin
                if (sel_ready) begin
                    if (accept) begin
                        state_d = BEAT1;
                        word_d  = Hyrja;
                        sel_d   = S;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign half_lo     = word_d[WIDTH-1:0];
    assign half_hi     = word_d[WordW-1:WIDTH];
    assign beat_first  = (HI_FIRST != 0) ? half_hi : half_lo;
    assign beat_second = (HI_FIRST != 0) ? half_lo : half_hi;

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        busy_d   = (state_d != IDLE);
        last_d   = (state_d == BEAT2);
        beat_d   = last_d ? beat_second : beat_first;
        valid0_d = busy_d && !sel_d;
        valid1_d = busy_d && sel_d;
        dalja0_d = valid0_d ? beat_d : '0;
        dalja1_d = valid1_d ? beat_d : '0;
    end

    // Single state/output register; reset drops any outstanding beats.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            sel_q    <= 1'b0;
            dalja0_q <= '0;
            dalja1_q <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            sel_q    <= sel_d;
            dalja0_q <= dalja0_d;
            dalja1_q <= dalja1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

    assign Dalja0 = dalja0_q;
    assign Dalja1 = dalja1_q;
    assign Valid0 = valid0_q;
    assign Valid1 = valid1_q;
    assign Last   = last_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_demux48_serializer_24.sv
// Directed vector bench for demux48_serializer_24, low-first and high-first builds.
module tb_demux48_serializer_24;

    logic        Clock;
    logic        Reset;
    logic [47:0] Hyrja;
    logic        S;
    logic        HyrjaValid;
    logic        Ready0;
    logic        Ready1;

    logic        hr_a, v0_a, v1_a, last_a, busy_a;
    logic [23:0] d0_a, d1_a;
    logic        hr_b, v0_b, v1_b, last_b, busy_b;
    logic [23:0] d0_b, d1_b;

    demux48_serializer_24 #(.WIDTH(24), .HI_FIRST(0)) dut_lo (
        .Clock(Clock), .Reset(Reset), .Hyrja(Hyrja), .S(S),
        .HyrjaValid(HyrjaValid), .HyrjaReady(hr_a),
        .Dalja0(d0_a), .Valid0(v0_a), .Ready0(Ready0),
        .Dalja1(d1_a), .Valid1(v1_a), .Ready1(Ready1),
        .Last(last_a), .Busy(busy_a)
    );

    demux48_serializer_24 #(.WIDTH(24), .HI_FIRST(1)) dut_hi (
        .Clock(Clock), .Reset(Reset), .Hyrja(Hyrja), .S(S),
        .HyrjaValid(HyrjaValid), .HyrjaReady(hr_b),
        .Dalja0(d0_b), .Valid0(v0_b), .Ready0(Ready0),
        .Dalja1(d1_b), .Valid1(v1_b), .Ready1(Ready1),
        .Last(last_b), .Busy(busy_b)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        rst_n;
        logic        hv;
        logic        s;
        logic [47:0] hyrja;
        logic        r0;
        logic        r1;
        logic        chk_hr;
        logic        hr;
        logic        v0;
        logic        v1;
        logic [23:0] d0;
        logic [23:0] d1;
        logic        last;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int row, input logic [47:0] act,
                       input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic hv, input logic s,
                       input logic [47:0] hyrja, input logic r0, input logic r1,
                       input logic chk_hr, input logic hr, input logic v0,
                       input logic v1, input logic [23:0] d0, input logic [23:0] d1,
                       input logic last, input logic busy);
        vec_t v;
        v.rst_n = rst_n; v.hv = hv; v.s = s; v.hyrja = hyrja; v.r0 = r0; v.r1 = r1;
        v.chk_hr = chk_hr; v.hr = hr; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1;
        v.last = last; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst_n, input logic hv, input logic s,
                         input logic [47:0] hyrja, input logic r0, input logic r1);
        Reset = rst_n; HyrjaValid = hv; S = s; Hyrja = hyrja; Ready0 = r0; Ready1 = r1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 48'h0, 1'b0, 1'b0);

        // Row fields: rst hv s hyrja r0 r1 | chk_hr hr | v0 v1 d0 d1 last busy (after edge)
        // reset, then idle
        add(0,0,0,48'h0,0,0,              0,0, 0,0,24'h0,24'h0,0,0);
        add(0,0,0,48'h0,0,0,              1,1, 0,0,24'h0,24'h0,0,0);
        // basic port 0, low half first
        add(1,1,0,48'hABCDEF_123456,1,0,  1,1, 1,0,24'h123456,24'h0,0,1);
        add(1,0,0,48'h0,1,0,              1,0, 1,0,24'hABCDEF,24'h0,1,1);
        add(1,0,0,48'h0,1,0,              1,1, 0,0,24'h0,24'h0,0,0);
        // back-pressure on port 1; Ready0 high must be ignored
        add(1,1,1,48'h000001_FFFFFF,1,0,  1,1, 0,1,24'h0,24'hFFFFFF,0,1);
        add(1,0,0,48'h0,1,0,              1,0, 0,1,24'h0,24'hFFFFFF,0,1);
        add(1,0,0,48'h0,1,0,              1,0, 0,1,24'h0,24'hFFFFFF,0,1);
        add(1,0,0,48'h0,1,0,              1,0, 0,1,24'h0,24'hFFFFFF,0,1);
        add(1,0,0,48'h0,0,1,              1,0, 0,1,24'h0,24'h000001,1,1);
        // stalled last beat: offered word is not taken
        add(1,1,0,48'h555555_AAAAAA,1,0,  1,0, 0,1,24'h0,24'h000001,1,1);
        add(1,0,0,48'h0,0,1,              1,1, 0,0,24'h0,24'h0,0,0);
        // back-to-back words, no idle gap
        add(1,1,0,48'h0A0B0C_0D0E0F,1,1,  1,1, 1,0,24'h0D0E0F,24'h0,0,1);
        add(1,1,0,48'h0A0B0C_0D0E0F,1,1,  1,0, 1,0,24'h0A0B0C,24'h0,1,1);
        add(1,1,1,48'h123123_456456,1,1,  1,1, 0,1,24'h0,24'h456456,0,1);
        add(1,0,0,48'h0,1,1,              1,0, 0,1,24'h0,24'h123123,1,1);
        add(1,0,0,48'h0,1,1,              1,1, 0,0,24'h0,24'h0,0,0);
        // reset during BEAT2 with consumer stalled
        add(1,1,0,48'hFEDCBA_987654,1,0,  1,1, 1,0,24'h987654,24'h0,0,1);
        add(1,0,0,48'h0,1,0,              1,0, 1,0,24'hFEDCBA,24'h0,1,1);
        add(0,0,0,48'h0,0,0,              1,0, 0,0,24'h0,24'h0,0,0);
        add(1,0,0,48'h0,1,0,              1,1, 0,0,24'h0,24'h0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].hv, vecs[i].s, vecs[i].hyrja, vecs[i].r0, vecs[i].r1);
            #1;
            if (vecs[i].chk_hr) chk("HyrjaReady", i, 48'(hr_a), 48'(vecs[i].hr));
            @(posedge Clock);
            #1;
            chk("Valid0", i, 48'(v0_a),   48'(vecs[i].v0));
            chk("Valid1", i, 48'(v1_a),   48'(vecs[i].v1));
            chk("Dalja0", i, 48'(d0_a),   48'(vecs[i].d0));
            chk("Dalja1", i, 48'(d1_a),   48'(vecs[i].d1));
            chk("Last",   i, 48'(last_a), 48'(vecs[i].last));
            chk("Busy",   i, 48'(busy_a), 48'(vecs[i].busy));
        end

        // High-half-first build: both instances idle here, same stimulus.
        drive(1'b1, 1'b1, 1'b0, 48'h111111_222222, 1'b1, 1'b0);
        @(posedge Clock);
        #1;
        chk("hi_first_beat1_data", 100, 48'(d0_b),   48'h111111);
        chk("hi_first_beat1_last", 100, 48'(last_b), 48'h0);
        chk("hi_first_beat1_v0",   100, 48'(v0_b),   48'h1);
        chk("lo_first_beat1_data", 100, 48'(d0_a),   48'h222222);
        drive(1'b1, 1'b0, 1'b0, 48'h0, 1'b1, 1'b0);
        @(posedge Clock);
        #1;
        chk("hi_first_beat2_data", 101, 48'(d0_b),   48'h222222);
        chk("hi_first_beat2_last", 101, 48'(last_b), 48'h1);
        chk("hi_first_beat2_v1",   101, 48'(v1_b),   48'h0);
        chk("lo_first_beat2_data", 101, 48'(d0_a),   48'h111111);
        @(posedge Clock);
        #1;
        chk("hi_first_done_busy",  102, 48'(busy_b), 48'h0);
        chk("hi_first_done_ready", 102, 48'(hr_b),   48'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
